// File: rtl/otp_pkg.sv
// -----------------------------------------------------------------------------
// otp_pkg
// Shared types and helpers for the one-time-pad keystream generator.
//   otp_state_e        : controller states (UNSEEDED, RUN, EXHAUSTED)
//   OTP_DEFAULT_*      : default key width / LFSR width / Galois taps
//   OTP_STEP_W         : working width of lfsr_step (covers any LFSR_W <= 64)
//   lfsr_step()        : one right-shift Galois LFSR step
// -----------------------------------------------------------------------------
package otp_pkg;

  typedef enum logic [1:0] {
    UNSEEDED  = 2'd0,
    RUN       = 2'd1,
    EXHAUSTED = 2'd2
  } otp_state_e;

  localparam int          OTP_DEFAULT_KEY_W  = 8;
  localparam int          OTP_DEFAULT_LFSR_W = 16;
  localparam logic [15:0] OTP_DEFAULT_POLY   = 16'hB400;

  // Callers zero-extend into this width; with zero upper bits in both the
  // state and the taps, the upper bits of the result stay zero.
  localparam int OTP_STEP_W = 64;

  function automatic logic [OTP_STEP_W-1:0] lfsr_step(
    input logic [OTP_STEP_W-1:0] x,
    input logic [OTP_STEP_W-1:0] poly
  );
    lfsr_step = (x >> 1) ^ (x[0] ? poly : '0);
  endfunction

endpackage

// File: rtl/otp_lfsr_stepk.sv
// -----------------------------------------------------------------------------
// otp_lfsr_stepk
// Combinational KEY_W-step Galois LFSR advance (fully unrolled).
// Ports:
//   state_in  [LFSR_W-1:0] : starting LFSR state
//   state_out [LFSR_W-1:0] : state after KEY_W consecutive steps
// -----------------------------------------------------------------------------
module otp_lfsr_stepk
  import otp_pkg::*;
#(
  parameter int               LFSR_W = OTP_DEFAULT_LFSR_W,
  parameter int               KEY_W  = OTP_DEFAULT_KEY_W,
  parameter logic [LFSR_W-1:0] POLY  = LFSR_W'(OTP_DEFAULT_POLY)
) (
  input  logic [LFSR_W-1:0] state_in,
  output logic [LFSR_W-1:0] state_out
);

  logic [OTP_STEP_W-1:0] chain [KEY_W+1];

  assign chain[0] = OTP_STEP_W'(state_in);

  for (genvar gi = 0; gi < KEY_W; gi++) begin : g_step
    assign chain[gi+1] = lfsr_step(chain[gi], OTP_STEP_W'(POLY));
  end

  assign state_out = chain[KEY_W][LFSR_W-1:0];

  // Upper bits of the working width are always zero; fold them into a sink.
  if (LFSR_W < OTP_STEP_W) begin : g_hi_sink
    logic unused_hi_bits;
    assign unused_hi_bits = ^chain[KEY_W][OTP_STEP_W-1:LFSR_W];
  end

endmodule

// File: rtl/otp_keystream_gen.sv
// -----------------------------------------------------------------------------
// otp_keystream_gen
// Pad-word source for the XOR one-time-pad stage. A seeded Galois LFSR is
// advanced KEY_W steps per delivered word; each seed yields at most MAX_USES
// words before a reseed is requested.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   seed_valid / seed_data / seed_ready : seed handshake (always ready)
//   key_valid / key_data / key_ready    : pad word handshake
//   reseed_req : high while UNSEEDED or EXHAUSTED
//   seed_err   : one-cycle pulse after an all-zero seed is rejected
//   uses_left  : pad words remaining for the current seed
// Build option:
//   OTP_KEY_WIPE_EN : zero key_data whenever key_valid is low and clear the
//                     LFSR on entry to EXHAUSTED.
// -----------------------------------------------------------------------------
module otp_keystream_gen
  import otp_pkg::*;
#(
  parameter int                KEY_W    = OTP_DEFAULT_KEY_W,
  parameter int                LFSR_W   = OTP_DEFAULT_LFSR_W,
  parameter logic [LFSR_W-1:0] POLY     = LFSR_W'(OTP_DEFAULT_POLY),
  parameter int                MAX_USES = 256,
  parameter int                CNT_W    = $clog2(MAX_USES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_valid,
  input  logic [LFSR_W-1:0] seed_data,
  output logic              seed_ready,
  output logic              key_valid,
  output logic [KEY_W-1:0]  key_data,
  input  logic              key_ready,
  output logic              reseed_req,
  output logic              seed_err,
  output logic [CNT_W-1:0]  uses_left
);

  otp_state_e        state_reg, state_next;
  logic [LFSR_W-1:0] lfsr_reg, lfsr_next;
  logic [CNT_W-1:0]  uses_reg, uses_next;
  logic              seed_err_reg;
  logic [LFSR_W-1:0] stepk_in, stepk_out;
  logic              seed_zero, seed_take, key_take, last_use;

  assign seed_zero = (seed_data == '0);
  assign seed_take = seed_valid && !seed_zero;   // seed_ready is constant 1
  assign key_take  = key_valid && key_ready;
  assign last_use  = key_take && (uses_reg == CNT_W'(1));

  // One stepper serves both paths; a seed takes priority over an advance.
  assign stepk_in = seed_take ? seed_data : lfsr_reg;

  otp_lfsr_stepk #(
    .LFSR_W (LFSR_W),
    .KEY_W  (KEY_W),
    .POLY   (POLY)
  ) u_stepk (
    .state_in  (stepk_in),
    .state_out (stepk_out)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= UNSEEDED;
    else        state_reg <= state_next;
  end

  // FSM: next state. A same-cycle seed overrides exhaustion of the old seed.
  always_comb begin
    state_next = state_reg;
    if (seed_take)     state_next = RUN;
    else if (last_use) state_next = EXHAUSTED;
  end

  // FSM: outputs decoded from registered state
  always_comb begin
    seed_ready = 1'b1;
    key_valid  = 1'b0;
    reseed_req = 1'b0;
    case (state_reg)
      RUN:       key_valid  = 1'b1;
      UNSEEDED:  reseed_req = 1'b1;
      EXHAUSTED: reseed_req = 1'b1;
      default:   reseed_req = 1'b1;
    endcase
  end

  // LFSR and use counter. key_take only occurs in RUN where uses_reg >= 1,
  // so the decrement cannot wrap; a fresh seed count is never decremented.
  always_comb begin
    lfsr_next = lfsr_reg;
    uses_next = uses_reg;
    if (seed_take) begin
      lfsr_next = stepk_out;
      uses_next = CNT_W'(MAX_USES);
    end else if (key_take) begin
      lfsr_next = stepk_out;
      uses_next = uses_reg - CNT_W'(1);
`ifdef OTP_KEY_WIPE_EN
      if (last_use) lfsr_next = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_reg     <= '0;
      uses_reg     <= '0;
      seed_err_reg <= 1'b0;
    end else begin
      lfsr_reg     <= lfsr_next;
      uses_reg     <= uses_next;
      seed_err_reg <= seed_valid && seed_zero;
    end
  end

  assign uses_left = uses_reg;
  assign seed_err  = seed_err_reg;

`ifdef OTP_KEY_WIPE_EN
  assign key_data = key_valid ? lfsr_reg[KEY_W-1:0] : '0;
`else
  assign key_data = lfsr_reg[KEY_W-1:0];
`endif

endmodule

// File: tb/tb_otp_keystream_gen.sv
// -----------------------------------------------------------------------------
// tb_otp_keystream_gen
// Directed scenarios for otp_keystream_gen with MAX_USES=4, KEY_W=8,
// LFSR_W=16, POLY=16'hB400. Expected pad words were worked out by hand:
//   seed ACE1 -> lfsr C2C4, EB62, 753B, 330D, then 0FBB after the 4th word
//   seed 1234 -> lfsr 3E32
// Inputs change just after a falling edge; outputs are checked at falling
// edges (or mid-cycle for the asynchronous reset check).
// -----------------------------------------------------------------------------
module tb_otp_keystream_gen;

  localparam int KEY_W    = 8;
  localparam int LFSR_W   = 16;
  localparam int MAX_USES = 4;
  localparam int CNT_W    = 3;

`ifdef OTP_KEY_WIPE_EN
  localparam logic [KEY_W-1:0] EXH_KEY = 8'h00;
`else
  localparam logic [KEY_W-1:0] EXH_KEY = 8'hBB;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              seed_valid = 1'b0;
  logic [LFSR_W-1:0] seed_data = '0;
  logic              seed_ready;
  logic              key_valid;
  logic [KEY_W-1:0]  key_data;
  logic              key_ready = 1'b0;
  logic              reseed_req;
  logic              seed_err;
  logic [CNT_W-1:0]  uses_left;

  int n_vec  = 0;
  int n_miss = 0;

  logic [KEY_W-1:0] ace_keys [4] = '{8'hC4, 8'h62, 8'h3B, 8'h0D};

  always #5 clk = ~clk;

  otp_keystream_gen #(
    .KEY_W    (KEY_W),
    .LFSR_W   (LFSR_W),
    .POLY     (16'hB400),
    .MAX_USES (MAX_USES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .seed_ready (seed_ready),
    .key_valid  (key_valid),
    .key_data   (key_data),
    .key_ready  (key_ready),
    .reseed_req (reseed_req),
    .seed_err   (seed_err),
    .uses_left  (uses_left)
  );

  task automatic test_reset();
    reset = 1'b0; seed_valid = 1'b0; seed_data = '0; key_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if (key_valid !== 1'b0) begin n_miss++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
    n_vec++; if (reseed_req !== 1'b1) begin n_miss++; $display("FAIL reset_reseed_req: got %b want 1", reseed_req); end
    n_vec++; if (seed_ready !== 1'b1) begin n_miss++; $display("FAIL reset_seed_ready: got %b want 1", seed_ready); end
    n_vec++; if (uses_left !== 3'd0) begin n_miss++; $display("FAIL reset_uses_left: got %0d want 0", uses_left); end
    n_vec++; if (key_data !== 8'h00) begin n_miss++; $display("FAIL reset_key_data: got %h want 00", key_data); end
    n_vec++; if (seed_err !== 1'b0) begin n_miss++; $display("FAIL reset_seed_err: got %b want 0", seed_err); end
    $display("test_reset: released, idle outputs checked");
  endtask

  task automatic test_zero_seed_unseeded();
    seed_valid = 1'b1; seed_data = 16'h0000;
    @(negedge clk);
    seed_valid = 1'b0;
    n_vec++; if (seed_err !== 1'b1) begin n_miss++; $display("FAIL zseed_err_pulse: got %b want 1", seed_err); end
    n_vec++; if (key_valid !== 1'b0) begin n_miss++; $display("FAIL zseed_key_valid: got %b want 0", key_valid); end
    n_vec++; if (reseed_req !== 1'b1) begin n_miss++; $display("FAIL zseed_reseed_req: got %b want 1", reseed_req); end
    n_vec++; if (uses_left !== 3'd0) begin n_miss++; $display("FAIL zseed_uses_left: got %0d want 0", uses_left); end
    @(negedge clk);
    n_vec++; if (seed_err !== 1'b0) begin n_miss++; $display("FAIL zseed_err_end: got %b want 0", seed_err); end
    n_vec++; if (key_valid !== 1'b0) begin n_miss++; $display("FAIL zseed_still_unseeded: got %b want 0", key_valid); end
    $display("test_zero_seed_unseeded: seed 0000 rejected");
  endtask

  task automatic test_seed_drain();
    seed_valid = 1'b1; seed_data = 16'hACE1;
    @(negedge clk);
    seed_valid = 1'b0;
    n_vec++; if (key_valid !== 1'b1) begin n_miss++; $display("FAIL drain_key_valid: got %b want 1", key_valid); end
    n_vec++; if (reseed_req !== 1'b0) begin n_miss++; $display("FAIL drain_reseed_req: got %b want 0", reseed_req); end
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (key_data !== ace_keys[i]) begin n_miss++; $display("FAIL drain_word%0d: got %h want %h", i, key_data, ace_keys[i]); end
      n_vec++; if (uses_left !== CNT_W'(MAX_USES - i)) begin n_miss++; $display("FAIL drain_uses%0d: got %0d want %0d", i, uses_left, MAX_USES - i); end
      n_vec++; if (key_valid !== 1'b1) begin n_miss++; $display("FAIL drain_valid%0d: got %b want 1", i, key_valid); end
      $display("test_seed_drain: word %0d = %h", i, key_data);
      @(negedge clk);
    end
    n_vec++; if (key_valid !== 1'b0) begin n_miss++; $display("FAIL exh_key_valid: got %b want 0", key_valid); end
    n_vec++; if (reseed_req !== 1'b1) begin n_miss++; $display("FAIL exh_reseed_req: got %b want 1", reseed_req); end
    n_vec++; if (uses_left !== 3'd0) begin n_miss++; $display("FAIL exh_uses_left: got %0d want 0", uses_left); end
    n_vec++; if (key_data !== EXH_KEY) begin n_miss++; $display("FAIL exh_key_data: got %h want %h", key_data, EXH_KEY); end
    @(negedge clk);  // key_ready still high while EXHAUSTED
    key_ready = 1'b0;
    n_vec++; if (uses_left !== 3'd0) begin n_miss++; $display("FAIL exh_no_wrap: got %0d want 0", uses_left); end
    n_vec++; if (key_valid !== 1'b0) begin n_miss++; $display("FAIL exh_hold_valid: got %b want 0", key_valid); end
    n_vec++; if (key_data !== EXH_KEY) begin n_miss++; $display("FAIL exh_hold_data: got %h want %h", key_data, EXH_KEY); end
  endtask

  task automatic test_stall();
    seed_valid = 1'b1; seed_data = 16'hACE1;
    @(negedge clk);
    seed_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (key_data !== 8'hC4) begin n_miss++; $display("FAIL stall_data%0d: got %h want c4", i, key_data); end
      n_vec++; if (uses_left !== 3'd4) begin n_miss++; $display("FAIL stall_uses%0d: got %0d want 4", i, uses_left); end
      @(negedge clk);
    end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    n_vec++; if (key_data !== 8'h62) begin n_miss++; $display("FAIL stall_release_data: got %h want 62", key_data); end
    n_vec++; if (uses_left !== 3'd3) begin n_miss++; $display("FAIL stall_release_uses: got %0d want 3", uses_left); end
    @(negedge clk);
    n_vec++; if (uses_left !== 3'd3) begin n_miss++; $display("FAIL stall_single_take: got %0d want 3", uses_left); end
    $display("test_stall: held 5 cycles, one word taken");
  endtask

  task automatic test_zero_seed_run();
    seed_valid = 1'b1; seed_data = 16'h0000; key_ready = 1'b1;
    @(negedge clk);
    seed_valid = 1'b0; key_ready = 1'b0;
    n_vec++; if (seed_err !== 1'b1) begin n_miss++; $display("FAIL zrun_seed_err: got %b want 1", seed_err); end
    n_vec++; if (key_valid !== 1'b1) begin n_miss++; $display("FAIL zrun_key_valid: got %b want 1", key_valid); end
    n_vec++; if (key_data !== 8'h3B) begin n_miss++; $display("FAIL zrun_key_data: got %h want 3b", key_data); end
    n_vec++; if (uses_left !== 3'd2) begin n_miss++; $display("FAIL zrun_uses: got %0d want 2", uses_left); end
    $display("test_zero_seed_run: sequence undisturbed");
  endtask

  task automatic test_seed_collision();
    key_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (key_data !== 8'h0D) begin n_miss++; $display("FAIL coll_pre_data: got %h want 0d", key_data); end
    n_vec++; if (uses_left !== 3'd1) begin n_miss++; $display("FAIL coll_pre_uses: got %0d want 1", uses_left); end
    seed_valid = 1'b1; seed_data = 16'h1234;
    @(negedge clk);
    seed_valid = 1'b0; key_ready = 1'b0;
    n_vec++; if (key_valid !== 1'b1) begin n_miss++; $display("FAIL coll_key_valid: got %b want 1", key_valid); end
    n_vec++; if (uses_left !== 3'd4) begin n_miss++; $display("FAIL coll_uses: got %0d want 4", uses_left); end
    n_vec++; if (key_data !== 8'h32) begin n_miss++; $display("FAIL coll_key_data: got %h want 32", key_data); end
    n_vec++; if (reseed_req !== 1'b0) begin n_miss++; $display("FAIL coll_reseed_req: got %b want 0", reseed_req); end
    $display("test_seed_collision: seed 1234 won over last word");
  endtask

  task automatic test_reset_mid_run();
    key_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_vec++; if (key_valid !== 1'b0) begin n_miss++; $display("FAIL rst_mid_key_valid: got %b want 0", key_valid); end
    n_vec++; if (uses_left !== 3'd0) begin n_miss++; $display("FAIL rst_mid_uses: got %0d want 0", uses_left); end
    n_vec++; if (reseed_req !== 1'b1) begin n_miss++; $display("FAIL rst_mid_reseed_req: got %b want 1", reseed_req); end
    n_vec++; if (key_data !== 8'h00) begin n_miss++; $display("FAIL rst_mid_key_data: got %h want 00", key_data); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    n_vec++; if (key_valid !== 1'b0) begin n_miss++; $display("FAIL rst_after_key_valid: got %b want 0", key_valid); end
    n_vec++; if (uses_left !== 3'd0) begin n_miss++; $display("FAIL rst_after_uses: got %0d want 0", uses_left); end
    $display("test_reset_mid_run: aborted transfer, back to UNSEEDED");
  endtask

  initial begin
    test_reset();
    test_zero_seed_unseeded();
    test_seed_drain();
    test_stall();
    test_zero_seed_run();
    test_seed_collision();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
